// File: rtl/sg_pkg.sv
// Shared state encoding, pipeline sideband type and default kernel for the
// streaming Savitzky-Golay smoother.
package sg_pkg;

  typedef logic [1:0] sg_state_t;

  localparam sg_state_t ST_IDLE  = 2'd0;
  localparam sg_state_t ST_FILL  = 2'd1;
  localparam sg_state_t ST_RUN   = 2'd2;
  localparam sg_state_t ST_FLUSH = 2'd3;

  typedef struct packed {
    logic vld;
    logic last;
  } sg_side_t;

  function automatic int sg_half(input int window);
    return window / 2;
  endfunction

  function automatic int sg_acc_w(input int data_w, input int coef_w, input int window);
    return data_w + coef_w + $clog2(window) + 1;
  endfunction

  // 15-point quadratic kernel (sums to 32768); any other length boots as a pass-through.
  function automatic int sg_default_coef(input int window, input int idx);
    int c;
    c = (idx == window / 2) ? 32767 : 0;
    if (window == 15) begin
      case (idx)
        0:       c = -2313;
        1:       c = -386;
        2:       c = 1246;
        3:       c = 2580;
        4:       c = 3618;
        5:       c = 4359;
        6:       c = 4804;
        7:       c = 4952;
        default: c = 0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sg_filter_stream_mac.sv
// Symmetric pre-add / multiply, adder tree, round and saturate: three registered
// stages that all advance together on i_en, with a valid/last sideband.
module sg_sym_mac
  import sg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WINDOW = 15,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 10,
  localparam int HALF  = WINDOW / 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic                             i_vld,
  input  logic                             i_last,
  input  logic [WINDOW-1:0][DATA_W-1:0]    i_win,
  input  logic [HALF:0][COEF_W-1:0]        i_coef,
  output logic                             o_vld,
  output logic                             o_last,
  output logic [OUT_W-1:0]                 o_data,
  output logic                             o_busy
);

  localparam int PROD_W = DATA_W + 2 + COEF_W;
  localparam int ACC_W  = sg_acc_w(DATA_W, COEF_W, WINDOW);

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(longint'(1) << (COEF_W - 2));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [DATA_W:0]            w_pre  [HALF+1];
  logic signed [PROD_W-1:0]   w_prod [HALF+1];
  logic signed [PROD_W-1:0]   r_prod [HALF+1];
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_rnd;
  logic signed [ACC_W-1:0]    w_shr;
  logic [OUT_W-1:0]           w_sat;

  sg_side_t                   r_s1;
  sg_side_t                   r_s2;
  logic                       r_out_vld;
  logic                       r_out_last;
  logic [OUT_W-1:0]           r_out_data;

  // Index 0 pairs the oldest and newest taps; index HALF is the unpaired centre.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    w_pre  = '{default: '0};
    w_prod = '{default: '0};
    for (int k = 0; k < HALF; k++) begin
      w_pre[k] = {1'b0, i_win[k]} + {1'b0, i_win[WINDOW-1-k]};
    end
    w_pre[HALF] = {1'b0, i_win[HALF]};
    for (int k = 0; k <= HALF; k++) begin
      w_prod[k] = PROD_W'($signed({1'b0, w_pre[k]})) * PROD_W'($signed(i_coef[k]));
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k <= HALF; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
  end

  assign w_rnd = r_acc + RND;
  assign w_shr = w_rnd >>> (COEF_W - 1);

  always_comb begin
    if (w_shr > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      w_sat = w_shr[OUT_W-1:0];
    end
  end

  // NOTE: arithmetic registers carry no reset; the sideband valid bits qualify them.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int k = 0; k <= HALF; k++) begin
        r_prod[k] <= w_prod[k];
      end
      r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else if (i_en) begin
      r_s1       <= '{vld: i_vld, last: i_vld & i_last};
      r_s2       <= r_s1;
      r_out_vld  <= r_s2.vld;
      r_out_last <= r_s2.vld & r_s2.last;
      if (r_s2.vld) begin
        r_out_data <= w_sat;
      end
    end
  end

  assign o_vld  = r_out_vld;
  assign o_last = r_out_last;
  assign o_data = r_out_data;
  assign o_busy = r_s1.vld | r_s2.vld | r_out_vld;

endmodule

// File: rtl/sg_filter_stream.sv
// Streaming Savitzky-Golay smoother: window shift register, runtime-loadable
// symmetric kernel, frame FSM with edge replication, and a stalling MAC pipeline.
module sg_filter_stream
  import sg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WINDOW = 15,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 10,
  localparam int HALF  = WINDOW / 2,
  localparam int IDX_W = $clog2(HALF + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_idx,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy
);

  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(HALF);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  sg_state_t                      r_state;
  logic [WINDOW-1:0][DATA_W-1:0]  r_win;
  logic                           r_win_vld;
  logic                           r_win_last;
  logic [HALF:0][COEF_W-1:0]      r_coef;
  logic [IDX_W-1:0]               r_cnt;
  logic [IDX_W-1:0]               r_rem;

  logic                           w_advance;
  logic                           w_accept;
  logic                           w_inject;
  logic                           w_shift;
  logic                           w_issue;
  logic [DATA_W-1:0]              w_new;
  logic                           w_mac_busy;

  assign w_advance = !(m_valid && !m_ready);
  assign s_ready   = w_advance && (r_state != ST_FLUSH);
  assign w_accept  = s_valid && s_ready;
  assign w_inject  = w_advance && (r_state == ST_FLUSH);
  assign w_shift   = w_accept || w_inject;
  // Flush replicates the most recent tap, i.e. the frame's last sample.
  assign w_new     = w_inject ? r_win[0] : s_data;

  // The item entering with index HALF is the first whose centre tap is sample 0,
  // so issuing from there on yields exactly one MAC per input sample.
  assign w_issue   = w_shift && (r_cnt == HALF_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win      <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else if (w_advance) begin
      // NOTE: non-blocking so each tap takes its neighbour's pre-edge value.
      r_win_vld  <= w_issue;
      r_win_last <= w_inject && (r_rem == ONE_IDX);
      if (w_shift) begin
        if (r_state == ST_IDLE) begin
          for (int i = 0; i <= HALF; i++) begin
            r_win[i] <= s_data;
          end
        end else begin
          r_win <= {r_win[WINDOW-2:0], w_new};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
    end else begin
      if (w_shift && (r_cnt != HALF_IDX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= s_last ? ST_FLUSH : ST_FILL;
            r_rem   <= HALF_IDX;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (s_last) begin
              r_state <= ST_FLUSH;
              r_rem   <= HALF_IDX;
            end else if (r_cnt == HALF_IDX) begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_accept && s_last) begin
            r_state <= ST_FLUSH;
            r_rem   <= HALF_IDX;
          end
        end
        ST_FLUSH: begin
          if (w_inject) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == ONE_IDX) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Writes only land while the pipeline is idle, so a frame never sees a mixed kernel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= HALF; i++) begin
        r_coef[i] <= COEF_W'(sg_default_coef(WINDOW, i));
      end
    end else begin
      for (int i = 0; i <= HALF; i++) begin
        if (coef_we && !busy && (coef_idx == IDX_W'(i))) begin
          r_coef[i] <= coef_wdata;
        end
      end
    end
  end

  sg_sym_mac #(
    .DATA_W (DATA_W),
    .WINDOW (WINDOW),
    .COEF_W (COEF_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_advance),
    .i_vld  (r_win_vld),
    .i_last (r_win_last),
    .i_win  (r_win),
    .i_coef (r_coef),
    .o_vld  (m_valid),
    .o_last (m_last),
    .o_data (m_data),
    .o_busy (w_mac_busy)
  );

  assign busy = (r_state != ST_IDLE) || r_win_vld || w_mac_busy;

endmodule
